// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store responder on the req/ack data bus (optional timeout: MEM_TIMEOUT_EN)
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_is,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_wb_wen,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        mem_stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   output logic [31:0] load_data,
   output logic [3:0]  err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state;
   logic [2:0]  acc_f3;
   logic [1:0]  acc_ofs;
   logic        acc_load;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic        is_load;
   logic        is_store;
   logic        pending;
   logic        misaligned;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ext_data;
   logic        timed_out;

   assign opcode = mem_is[6:0];
   assign f3     = mem_is[14:12];

   // Decode the MEM instruction into a legal load/store and its alignment fault
   always_comb begin
      is_load    = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      if (opcode == 7'b0000011)
         is_load = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
      if (opcode == 7'b0100011)
         is_store = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      if (f3[1:0] == 2'b01)
         misaligned = mem_addr[0];
      else if (f3[1:0] == 2'b10)
         misaligned = (mem_addr[1:0] != 2'b00);
   end

   assign pending   = is_load || is_store;
   assign mem_stall = ((state == ST_IDLE) && pending) || (state == ST_REQ);

   // Store lane strobes and lane-replicated data; loads drive no lanes
   always_comb begin
      st_strb = 4'b0000;
      st_data = 32'h0;
      if (is_store) begin
         case (f3[1:0])
            2'b00: begin
               st_strb = 4'b0001 << mem_addr[1:0];
               st_data = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
               st_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
               st_data = {2{mem_wdata[15:0]}};
            end
            default: begin
               st_strb = 4'b1111;
               st_data = mem_wdata;
            end
         endcase
      end
   end

   // Select and extend the loaded byte/halfword from the acked word
   always_comb begin
      case (acc_ofs)
         2'd0:    byte_v = bus_rdata[7:0];
         2'd1:    byte_v = bus_rdata[15:8];
         2'd2:    byte_v = bus_rdata[23:16];
         default: byte_v = bus_rdata[31:24];
      endcase
      half_v = acc_ofs[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (acc_f3)
         3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
         3'b001:  ext_data = {{16{half_v[15]}}, half_v};
         3'b100:  ext_data = {24'h0, byte_v};
         3'b101:  ext_data = {16'h0, half_v};
         default: ext_data = bus_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tmo_cnt;
   logic       unused_bits;

   assign unused_bits = ^{mem_is[31:15], mem_is[11:7]};
   assign timed_out   = (state == ST_REQ) && !bus_ack && (tmo_cnt >= TMO_LAST);

   // Count cycles spent in REQ, cleared on entry and saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         tmo_cnt <= 8'h0;
      else if (state == ST_IDLE)
         tmo_cnt <= 8'h0;
      else if ((state == ST_REQ) && (tmo_cnt != 8'hFF))
         tmo_cnt <= tmo_cnt + 8'h1;
   end
`else
   logic unused_bits;

   assign unused_bits = ^{mem_is[31:15], mem_is[11:7], 32'(TIMEOUT)};
   assign timed_out   = 1'b0;
`endif

   // Transaction FSM: launch the bus access, capture the result, hold until writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wstrb <= 4'h0;
         bus_wdata <= 32'h0;
         load_data <= 32'h0;
         err       <= 4'h0;
         acc_f3    <= 3'h0;
         acc_ofs   <= 2'h0;
         acc_load  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  if (misaligned) begin
                     state     <= ST_DONE;
                     err       <= is_load ? 4'd1 : 4'd2;
                     load_data <= 32'h0;
                  end else begin
                     state     <= ST_REQ;
                     bus_req   <= 1'b1;
                     bus_we    <= is_store;
                     bus_addr  <= {mem_addr[31:2], 2'b00};
                     bus_wstrb <= st_strb;
                     bus_wdata <= st_data;
                     acc_f3    <= f3;
                     acc_ofs   <= mem_addr[1:0];
                     acc_load  <= is_load;
                  end
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  state   <= ST_DONE;
                  bus_req <= 1'b0;
                  if (acc_load)
                     load_data <= ext_data;
               end else if (timed_out) begin
                  state     <= ST_DONE;
                  bus_req   <= 1'b0;
                  err       <= 4'd3;
                  load_data <= 32'h0;
               end
            end
            ST_DONE: begin
               if (mem_wb_wen) begin
                  state <= ST_IDLE;
                  err   <= 4'd0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

   localparam logic [31:0] I_NOP = 32'h0000_0013;
   localparam logic [31:0] I_LB  = 32'h0000_0003;
   localparam logic [31:0] I_LW  = 32'h0000_2003;
   localparam logic [31:0] I_LD  = 32'h0000_3003;
   localparam logic [31:0] I_LBU = 32'h0000_4003;
   localparam logic [31:0] I_LHU = 32'h0000_5003;
   localparam logic [31:0] I_SB  = 32'h0000_0023;
   localparam logic [31:0] I_SH  = 32'h0000_1023;
   localparam logic [31:0] I_SW  = 32'h0000_2023;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_is;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wb_wen;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        mem_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic [31:0] load_data;
   logic [3:0]  err;

   int checks = 0;
   int failures = 0;
   int stalls;
   int reqs;
   logic        snap_we;
   logic [31:0] snap_addr;
   logic [3:0]  snap_strb;
   logic [31:0] snap_wdata;
   logic        stable;
   logic [31:0] held;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_is(mem_is), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wb_wen(mem_wb_wen), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .mem_stall(mem_stall), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
      .bus_wdata(bus_wdata), .load_data(load_data), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one access and serve it; k < 0 never acks. Stops once mem_stall drops.
   task automatic run_access(input logic [31:0] is, input logic [31:0] addr, input logic [31:0] wd,
                             input int k, input logic [31:0] rd);
      mem_is = is; mem_addr = addr; mem_wdata = wd; mem_wb_wen = 1'b0;
      bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
      stalls = 0; reqs = 0; stable = 1'b1;
      #1;
      for (int c = 0; c < 300 && mem_stall; c++) begin
         stalls++;
         if (bus_req) begin
            if (reqs == 0) begin
               snap_we = bus_we; snap_addr = bus_addr; snap_strb = bus_wstrb; snap_wdata = bus_wdata;
            end else if (bus_we !== snap_we || bus_addr !== snap_addr ||
                         bus_wstrb !== snap_strb || bus_wdata !== snap_wdata) begin
               stable = 1'b0;
            end
            bus_ack   = (reqs == k);
            bus_rdata = (reqs == k) ? rd : 32'h0BAD_0BAD;
            reqs++;
         end
         tick();
         bus_ack = 1'b0;
         bus_rdata = 32'h0BAD_0BAD;
      end
      check("stall_bound", {31'h0, mem_stall}, 32'h0);
   endtask

   task automatic retire();
      mem_wb_wen = 1'b1;
      tick();
      mem_wb_wen = 1'b0;
      mem_is = I_NOP;
      #1;
   endtask

   initial begin
      rst = 1'b1; mem_is = I_NOP; mem_addr = 32'h0; mem_wdata = 32'h0;
      mem_wb_wen = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_stall", {31'h0, mem_stall}, 32'h0);
      check("rst_req",   {31'h0, bus_req}, 32'h0);
      check("rst_we",    {31'h0, bus_we}, 32'h0);
      check("rst_addr",  bus_addr, 32'h0);
      check("rst_strb",  {28'h0, bus_wstrb}, 32'h0);
      check("rst_wdata", bus_wdata, 32'h0);
      check("rst_ldata", load_data, 32'h0);
      check("rst_err",   {28'h0, err}, 32'h0);

      run_access(I_LW, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
      check("lw_stalls", stalls, 5);
      check("lw_reqs",   reqs, 4);
      check("lw_addr",   snap_addr, 32'h100);
      check("lw_we",     {31'h0, snap_we}, 32'h0);
      check("lw_strb",   {28'h0, snap_strb}, 32'h0);
      check("lw_stable", {31'h0, stable}, 32'h1);
      check("lw_data",   load_data, 32'hDEAD_BEEF);
      check("lw_err",    {28'h0, err}, 32'h0);
      check("lw_req_off", {31'h0, bus_req}, 32'h0);
      held = load_data;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_data",  load_data, held);
         check("hold_stall", {31'h0, mem_stall}, 32'h0);
      end
      retire();
      check("retire_stall", {31'h0, mem_stall}, 32'h0);

      run_access(I_LB, 32'h103, 32'h0, 0, 32'h8012_3456);
      check("lb_stalls", stalls, 2);
      check("lb_data",   load_data, 32'hFFFF_FF80);
      retire();
      run_access(I_LBU, 32'h103, 32'h0, 1, 32'h8012_3456);
      check("lbu_data",  load_data, 32'h0000_0080);
      retire();
      run_access(I_LHU, 32'h102, 32'h0, 2, 32'h8012_3456);
      check("lhu_data",  load_data, 32'h0000_8012);
      retire();

      run_access(I_SH, 32'h202, 32'h0000_ABCD, 1, 32'h0);
      check("sh_addr",  snap_addr, 32'h200);
      check("sh_strb",  {28'h0, snap_strb}, 32'hC);
      check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
      check("sh_we",    {31'h0, snap_we}, 32'h1);
      check("sh_err",   {28'h0, err}, 32'h0);
      retire();
      run_access(I_SB, 32'h301, 32'h0000_00A5, 0, 32'h0);
      check("sb_strb",  {28'h0, snap_strb}, 32'h2);
      check("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
      retire();

      run_access(I_LW, 32'h101, 32'h0, 0, 32'h0);
      check("mis_ld_stalls", stalls, 1);
      check("mis_ld_reqs",   reqs, 0);
      check("mis_ld_err",    {28'h0, err}, 32'h1);
      retire();
      check("mis_err_clr",   {28'h0, err}, 32'h0);
      run_access(I_SW, 32'h102, 32'h1234_5678, 0, 32'h0);
      check("mis_st_stalls", stalls, 1);
      check("mis_st_err",    {28'h0, err}, 32'h2);
      retire();

      mem_is = I_LD; mem_addr = 32'h100;
      #1;
      check("illegal_f3_stall", {31'h0, mem_stall}, 32'h0);
      tick();
      check("illegal_f3_req", {31'h0, bus_req}, 32'h0);
      mem_is = I_NOP;

`ifdef MEM_TIMEOUT_EN
      run_access(I_LW, 32'h400, 32'h0, -1, 32'h0);
      check("tmo_reqs",  reqs, 4);
      check("tmo_stalls", stalls, 5);
      check("tmo_err",   {28'h0, err}, 32'h3);
      check("tmo_data",  load_data, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      tick();
      bus_ack = 1'b0;
      check("late_ack_err",  {28'h0, err}, 32'h3);
      check("late_ack_data", load_data, 32'h0);
      check("late_ack_req",  {31'h0, bus_req}, 32'h0);
      retire();
`else
      run_access(I_LW, 32'h400, 32'h0, 10, 32'h1357_9BDF);
      check("long_wait_stalls", stalls, 12);
      check("long_wait_err",    {28'h0, err}, 32'h0);
      check("long_wait_data",   load_data, 32'h1357_9BDF);
      retire();
`endif

      mem_is = I_LW; mem_addr = 32'h500;
      tick();
      check("mid_req", {31'h0, bus_req}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0; mem_is = I_NOP;
      #1;
      check("mid_rst_req",   {31'h0, bus_req}, 32'h0);
      check("mid_rst_stall", {31'h0, mem_stall}, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0;
      check("post_rst_ack_data",  load_data, 32'h0);
      check("post_rst_ack_stall", {31'h0, mem_stall}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
